// File: rtl/stack_core.sv
// stack_core: single-issue two-stack machine with data/return stacks, a
// req/ack data-memory port, pause, and a sticky stack-fault halt.
//
//   state | meaning
//   RUN   | one instruction committed per cycle (unless paused)
//   MEM   | data-memory access outstanding; commit on i_ram_ack
//   FAULT | stack over/underflow seen; everything frozen until i_rst
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_pause (hold state in RUN)
//   o_rom_addr / i_rom_data : instruction fetch (combinational ROM)
//   o_ram_req/we/addr/dout, i_ram_din, i_ram_ack : data-memory handshake
//   o_fault {R,D} sticky fault flags, o_halted high in FAULT
module stack_core #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int DSTK_DEPTH     = 16,
  parameter int RSTK_DEPTH     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_pause,
  output logic [ADDR_WIDTH-1:0]     o_rom_addr,
  input  logic [15:0]               i_rom_data,
  output logic                      o_ram_req,
  output logic                      o_ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]     o_ram_dout,
  input  logic [DATA_WIDTH-1:0]     i_ram_din,
  input  logic                      i_ram_ack,
  output logic [1:0]                o_fault,
  output logic                      o_halted
);
  localparam int DIW = $clog2(DSTK_DEPTH);
  localparam int DCW = DIW + 1;
  localparam int RIW = $clog2(RSTK_DEPTH);
  localparam int RCW = RIW + 1;

  typedef enum logic [1:0] {RUN, MEM, FAULT} state_t;
  state_t state, state_nxt;

  logic [15:0]           inst;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, pc_inc, target, r, r_wdata;
  logic [DATA_WIDTH-1:0] t, t_nxt, n, alu;
  logic                  t_live, t_live_nxt;
  logic [DCW-1:0]        dd, dd_nxt, dd_m1;
  logic [RCW-1:0]        rd, rd_nxt, rd_m1;
  logic [DATA_WIDTH-1:0] dstk [DSTK_DEPTH];
  logic [ADDR_WIDTH-1:0] rstk [RSTK_DEPTH];
  logic [1:0]            fault;
  logic                  is_alu, mem_wr, mem_op, d_push, d_pop, d_spill, r_push, r_pop;
  logic                  d_err, r_err, commit, fault_now, apply;
  logic [3:0]            op, op_eff;
  logic                  unused_bits;

  assign inst        = i_rom_data;
  assign unused_bits = ^{inst[7:6], inst[4]};

  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign target  = inst[ADDR_WIDTH-1:0];
  assign dd_m1   = dd - DCW'(1);
  assign rd_m1   = rd - RCW'(1);
  assign n       = dstk[dd_m1[DIW-1:0]];
  assign r       = rstk[rd_m1[RIW-1:0]];

  // Decode
  assign is_alu  = inst[15:13] == 3'b011;
  assign op      = inst[11:8];
  assign mem_wr  = is_alu & inst[5];
  assign mem_op  = mem_wr | (is_alu & (op == 4'd12));
  // A write wins over a read in the same instruction; the read op degrades to "keep T".
  assign op_eff  = (mem_wr && op == 4'd12) ? 4'd0 : op;
  assign d_push  = inst[15] | (is_alu & (inst[1:0] == 2'b01));
  assign d_pop   = (inst[15:13] == 3'b001) | (is_alu & (inst[1:0] == 2'b11));
  assign r_push  = (inst[15:13] == 3'b010) | (is_alu & (inst[3:2] == 2'b01));
  assign r_pop   = is_alu & (inst[3:2] == 2'b11);
  assign r_wdata = is_alu ? t[ADDR_WIDTH-1:0] : pc_inc;

  // After reset T holds no live value, so the first push only fills T
  // and does not spill into the stack array.
  assign d_spill = d_push & t_live;
  assign d_err   = (d_spill & (dd == DCW'(DSTK_DEPTH))) | (d_pop & (dd == '0));
  assign r_err   = (r_push & (rd == RCW'(RSTK_DEPTH))) | (r_pop & (rd == '0));

  assign commit    = ((state == RUN) & ~i_pause & ~mem_op) | ((state == MEM) & i_ram_ack);
  assign fault_now = commit & (d_err | r_err);
  assign apply     = commit & ~(d_err | r_err);

  always_comb begin
    alu = t;
    case (op_eff)
      4'd1:    alu = n;
      4'd2:    alu = t + n;
      4'd3:    alu = t & n;
      4'd4:    alu = t | n;
      4'd5:    alu = t ^ n;
      4'd6:    alu = ~t;
      4'd7:    alu = {DATA_WIDTH{n == t}};
      4'd8:    alu = {DATA_WIDTH{$signed(n) < $signed(t)}};
      4'd9:    alu = n >> t[3:0];
      4'd10:   alu = t - DATA_WIDTH'(1);
      4'd11:   alu = DATA_WIDTH'(r);
      4'd12:   alu = i_ram_din;
      4'd13:   alu = n << t[3:0];
      4'd14:   alu = DATA_WIDTH'(dd);
      4'd15:   alu = {DATA_WIDTH{n < t}};
      default: alu = t;
    endcase
  end

  always_comb begin
    pc_nxt     = pc;
    t_nxt      = t;
    t_live_nxt = t_live;
    dd_nxt     = dd;
    rd_nxt     = rd;
    if (apply) begin
      if (inst[15]) begin
        t_nxt  = DATA_WIDTH'(inst[14:0]);
        pc_nxt = pc_inc;
      end else begin
        case (inst[14:13])
          2'b00:   pc_nxt = target;
          2'b01: begin
            pc_nxt = (t == '0) ? target : pc_inc;
            t_nxt  = n;
          end
          2'b10:   pc_nxt = target;
          default: begin
            t_nxt  = alu;
            pc_nxt = inst[12] ? r : pc_inc;
          end
        endcase
      end
      if (d_push) begin
        t_live_nxt = 1'b1;
        if (t_live) dd_nxt = dd + DCW'(1);
      end
      if (d_pop)  dd_nxt = dd_m1;
      if (r_push) rd_nxt = rd + RCW'(1);
      if (r_pop)  rd_nxt = rd_m1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc     <= '0;
      t      <= '0;
      t_live <= 1'b0;
      dd     <= '0;
      rd     <= '0;
      fault  <= '0;
    end else begin
      pc     <= pc_nxt;
      t      <= t_nxt;
      t_live <= t_live_nxt;
      dd     <= dd_nxt;
      rd     <= rd_nxt;
      if (fault_now) fault <= {r_err, d_err};
    end
  end

  // Stack storage is deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && apply) begin
      if (d_spill) dstk[dd[DIW-1:0]] <= t;
      if (r_push)  rstk[rd[RIW-1:0]] <= r_wdata;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (fault_now)              state_nxt = FAULT;
        else if (!i_pause && mem_op) state_nxt = MEM;
      end
      MEM: begin
        if (i_ram_ack) state_nxt = fault_now ? FAULT : RUN;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ram_req = (state == MEM);
    o_ram_we  = (state == MEM) & inst[5];
    o_halted  = (state == FAULT);
  end

  assign o_rom_addr = pc;
  assign o_ram_addr = t[RAM_ADDR_WIDTH-1:0];
  assign o_ram_dout = n;
  assign o_fault    = fault;
endmodule

// File: tb/tb_stack_core.sv
module tb_stack_core;
  localparam int DSTK = 4;
  localparam int RSTK = 4;

  logic        clk = 1'b0;
  logic        rst, pause, ack;
  logic [15:0] din;
  logic [11:0] rom_addr, ram_addr;
  logic [15:0] rom_data, ram_dout;
  logic        ram_req, ram_we, halted;
  logic [1:0]  fault;
  logic [15:0] rom [4096];

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  stack_core #(
    .DATA_WIDTH(16), .ADDR_WIDTH(12), .RAM_ADDR_WIDTH(12),
    .DSTK_DEPTH(DSTK), .RSTK_DEPTH(RSTK)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pause(pause),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_ram_req(ram_req), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_dout(ram_dout), .i_ram_din(din), .i_ram_ack(ack),
    .o_fault(fault), .o_halted(halted)
  );

  // Behavioural model: stacks as queues (entries below T), mode 0 run / 1 waiting on memory / 2 halted
  logic [11:0] m_pc = '0;
  logic [15:0] m_t = '0;
  bit          m_tlive = 0;
  logic [15:0] mds [$];
  logic [11:0] rs [$];
  int          m_mode = 0;
  logic [1:0]  m_fault = '0;

  int n_pass = 0, n_total = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_mem(input logic [15:0] ins);
    return ins[15:13] == 3'b011 && (ins[5] || ins[11:8] == 4'd12);
  endfunction

  task automatic execute(input logic [15:0] ins);
    logic [11:0] pc1, tgt, rv;
    logic [15:0] nv, res;
    logic [3:0]  op;
    bit dpush, dpop, rpush, rpop, derr, rerr;
    pc1   = m_pc + 12'd1;
    tgt   = ins[11:0];
    nv    = (mds.size() > 0) ? mds[$] : 16'h0;
    rv    = (rs.size() > 0) ? rs[$] : 12'h0;
    dpush = ins[15] || (ins[15:13] == 3'b011 && ins[1:0] == 2'b01);
    dpop  = ins[15:13] == 3'b001 || (ins[15:13] == 3'b011 && ins[1:0] == 2'b11);
    rpush = ins[15:13] == 3'b010 || (ins[15:13] == 3'b011 && ins[3:2] == 2'b01);
    rpop  = ins[15:13] == 3'b011 && ins[3:2] == 2'b11;
    derr  = (dpush && m_tlive && mds.size() == DSTK) || (dpop && mds.size() == 0);
    rerr  = (rpush && rs.size() == RSTK) || (rpop && rs.size() == 0);
    if (derr || rerr) begin
      m_fault = {rerr, derr};
      m_mode  = 2;
      return;
    end
    res = m_t;
    if (ins[15]) begin
      res  = {1'b0, ins[14:0]};
      m_pc = pc1;
    end else begin
      case (ins[14:13])
        2'd0: m_pc = tgt;
        2'd1: begin m_pc = (m_t == 0) ? tgt : pc1; res = nv; end
        2'd2: m_pc = tgt;
        default: begin
          op = ins[11:8];
          if (ins[5] && op == 4'd12) op = 4'd0;
          case (op)
            4'd0:  res = m_t;
            4'd1:  res = nv;
            4'd2:  res = m_t + nv;
            4'd3:  res = m_t & nv;
            4'd4:  res = m_t | nv;
            4'd5:  res = m_t ^ nv;
            4'd6:  res = ~m_t;
            4'd7:  res = (nv == m_t) ? 16'hFFFF : 16'h0;
            4'd8:  res = ($signed(nv) < $signed(m_t)) ? 16'hFFFF : 16'h0;
            4'd9:  res = nv >> m_t[3:0];
            4'd10: res = m_t - 16'd1;
            4'd11: res = {4'h0, rv};
            4'd12: res = din;
            4'd13: res = nv << m_t[3:0];
            4'd14: res = 16'(mds.size());
            default: res = (nv < m_t) ? 16'hFFFF : 16'h0;
          endcase
          m_pc = ins[12] ? rv : pc1;
        end
      endcase
    end
    if (dpush) begin
      if (m_tlive) mds.push_back(m_t);
      m_tlive = 1;
    end
    if (dpop) void'(mds.pop_back());
    if (rpush) rs.push_back((ins[15:13] == 3'b010) ? pc1 : m_t[11:0]);
    if (rpop) void'(rs.pop_back());
    m_t = res;
  endtask

  task automatic model_step();
    logic [15:0] ins;
    if (rst) begin
      m_pc = '0; m_t = '0; m_tlive = 0; mds.delete(); rs.delete();
      m_mode = 0; m_fault = '0;
      return;
    end
    ins = rom[m_pc];
    case (m_mode)
      0: if (!pause) begin
        if (is_mem(ins)) m_mode = 1;
        else execute(ins);
      end
      1: if (ack) begin
        m_mode = 0;
        execute(ins);
      end
      default: ;
    endcase
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    logic [15:0] cur;
    if (chk_en) begin
      cur = rom[m_pc];
      check("pc", 32'(rom_addr), 32'(m_pc));
      check("ram_addr", 32'(ram_addr), 32'(m_t[11:0]));
      check("ram_req", 32'(ram_req), 32'(m_mode == 1));
      check("ram_we", 32'(ram_we), 32'(m_mode == 1 && cur[5]));
      if (mds.size() > 0) check("ram_dout", 32'(ram_dout), 32'(mds[$]));
      check("fault", 32'(fault), 32'(m_fault));
      check("halted", 32'(halted), 32'(m_mode == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic begin_test();
    rst = 1; pause = 0; ack = 0; din = '0;
    tick();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
  endtask

  task automatic go();
    tick();
    rst = 0;
  endtask

  int reqcnt;

  initial begin
    rst = 1; pause = 0; ack = 0; din = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    tick(); tick();
    chk_en = 1;
    check("rst_pc", 32'(rom_addr), 32'h0);
    check("rst_req", 32'(ram_req), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // lit 5, lit 3, add with D pop, then read D depth
    begin_test();
    rom[0] = 16'h8005; rom[1] = 16'h8003; rom[2] = 16'h6203; rom[3] = 16'h6E00; rom[4] = 16'h0004;
    go();
    tick(); tick(); tick();
    check("add_pc", 32'(rom_addr), 32'h3);
    check("add_t", 32'(ram_addr), 32'h008);
    tick();
    check("add_ddepth", 32'(ram_addr), 32'h000);

    // same program, paused every other cycle
    begin_test();
    rom[0] = 16'h8005; rom[1] = 16'h8003; rom[2] = 16'h6203; rom[3] = 16'h0003;
    go();
    pause = 1; tick();
    check("pause_hold_pc", 32'(rom_addr), 32'h0);
    pause = 0; tick();
    repeat (2) begin pause = 1; tick(); pause = 0; tick(); end
    check("pause_pc", 32'(rom_addr), 32'h3);
    check("pause_t", 32'(ram_addr), 32'h008);

    // CALL / return with R pop, then a second return underflows R
    begin_test();
    rom[0] = 16'h4010; rom[1] = 16'h700C; rom[16] = 16'h700C;
    go();
    tick();
    check("call_pc", 32'(rom_addr), 32'h010);
    tick();
    check("ret_pc", 32'(rom_addr), 32'h001);
    check("ret_fault", 32'(fault), 32'h0);
    tick();
    check("r_under_fault", 32'(fault), 32'h2);
    check("r_under_halt", 32'(halted), 32'h1);
    tick();
    check("r_under_pc", 32'(rom_addr), 32'h001);

    // Memory write with three wait states
    begin_test();
    rom[0] = 16'h9234; rom[1] = 16'h8020; rom[2] = 16'h6123; rom[3] = 16'h0003;
    go();
    tick(); tick(); tick();
    check("wr_we", 32'(ram_we), 32'h1);
    check("wr_addr", 32'(ram_addr), 32'h020);
    check("wr_dout", 32'(ram_dout), 32'h1234);
    reqcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ram_req) reqcnt++;
      if (i < 3) check("wr_stall_pc", 32'(rom_addr), 32'h2);
      ack = (i == 3);
      tick();
    end
    ack = 0;
    if (ram_req) reqcnt++;
    check("wr_req_cycles", 32'(reqcnt), 32'd4);
    check("wr_done_pc", 32'(rom_addr), 32'h3);
    check("wr_done_t", 32'(ram_addr), 32'h234);

    // Reset while a request is outstanding
    begin_test();
    rom[0] = 16'h9234; rom[1] = 16'h8020; rom[2] = 16'h6123; rom[3] = 16'h0003;
    go();
    tick(); tick(); tick();
    check("abort_req_before", 32'(ram_req), 32'h1);
    rst = 1; tick();
    check("abort_req_after", 32'(ram_req), 32'h0);
    rst = 0;

    // Memory read, two waits, pause held through the access
    begin_test();
    rom[0] = 16'h8020; rom[1] = 16'h6C00; rom[2] = 16'h8000; rom[3] = 16'h0003;
    go();
    tick(); tick();
    check("rd_req", 32'(ram_req), 32'h1);
    check("rd_we", 32'(ram_we), 32'h0);
    pause = 1; tick(); tick();
    check("rd_wait_pc", 32'(rom_addr), 32'h1);
    ack = 1; din = 16'hBEEF; tick();
    ack = 0; din = '0; pause = 0;
    check("rd_pc", 32'(rom_addr), 32'h2);
    check("rd_t", 32'(ram_addr), 32'hEEF);
    tick();
    check("rd_n", 32'(ram_dout), 32'hBEEF);

    // D overflow at depth 4
    begin_test();
    for (int i = 0; i < 6; i++) rom[i] = 16'(16'h8001 + i);
    rom[6] = 16'h0006;
    go();
    repeat (5) tick();
    check("ovf_pre_fault", 32'(fault), 32'h0);
    tick();
    check("ovf_fault", 32'(fault), 32'h1);
    check("ovf_halt", 32'(halted), 32'h1);
    check("ovf_pc", 32'(rom_addr), 32'h5);
    check("ovf_t", 32'(ram_addr), 32'h005);
    tick();
    check("ovf_frozen_pc", 32'(rom_addr), 32'h5);
    rst = 1; tick();
    check("ovf_clr_fault", 32'(fault), 32'h0);
    check("ovf_clr_halt", 32'(halted), 32'h0);
    rst = 0;

    // JZ on an empty data stack, free-running and paused
    begin_test();
    rom[0] = 16'h2005;
    go();
    tick();
    check("jz_fault", 32'(fault), 32'h1);
    check("jz_pc", 32'(rom_addr), 32'h0);
    begin_test();
    rom[0] = 16'h2005;
    go();
    pause = 1; tick();
    check("jz_pause_hold", 32'(fault), 32'h0);
    pause = 0; tick();
    check("jz_pause_fault", 32'(fault), 32'h1);

    // ALU op mix
    begin_test();
    rom[0] = 16'h80F0; rom[1] = 16'h8003; rom[2] = 16'h6D00; rom[3] = 16'h6A00;
    rom[4] = 16'h6500;  rom[5] = 16'h6F00; rom[6] = 16'h6600; rom[7] = 16'h6800;
    rom[8] = 16'h6900;  rom[9] = 16'h6700; rom[10] = 16'h000A;
    go();
    repeat (3) tick();
    check("alu_shl", 32'(ram_addr), 32'h780);
    repeat (3) tick();
    check("alu_ult", 32'(ram_addr), 32'hFFF);
    repeat (4) tick();
    check("alu_eq", 32'(ram_addr), 32'hFFF);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
